// File: rtl/scoreboard_ctrl.sv
// Decode-stage issue controller: per-register pending-write counters, RAW/structural stall and branch flush.
// Optional SB_WB_BYPASS_EN lets a consumer issue in the same cycle as its producer's final write-back.
module scoreboard_ctrl #(
  parameter int NUM_REGS     = 32,
  parameter int ADDR_W       = 5,
  parameter int CNT_W        = 2,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_src1,
  input  logic [ADDR_W-1:0] id_src2,
  input  logic              id_use_src2,
  input  logic [ADDR_W-1:0] id_dest,
  input  logic              id_wb_en,
  input  logic              ex_br_taken,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_dest,
  output logic              stall,
  output logic              issue,
  output logic              flush,
  output logic              busy,
  output logic              sb_err
);

  localparam int FL_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [FL_W-1:0]  FL_LOAD  = FL_W'(FLUSH_CYCLES - 1);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t            state;
  logic [FL_W-1:0]   flush_left;
  logic [CNT_W-1:0]  cnt [NUM_REGS];

  logic              hazard1;
  logic              hazard2;
  logic              full;
  logic              wb_spur;
  logic [NUM_REGS-1:0] inc_vec;
  logic [NUM_REGS-1:0] dec_vec;

  // Same-cycle inc and dec cancel; saturation and underflow are blocked upstream.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cur,
                                                input logic inc, input logic dec);
    logic [CNT_W-1:0] nxt;
    nxt = cur;
    if (inc && !dec && cur != CNT_MAX)
      nxt = cur + 1'b1;
    else if (dec && !inc && cur != '0)
      nxt = cur - 1'b1;
    return nxt;
  endfunction

  always_comb begin
    hazard1 = (id_src1 != '0) && (cnt[id_src1] != '0);
    hazard2 = id_use_src2 && (id_src2 != '0) && (cnt[id_src2] != '0);
`ifdef SB_WB_BYPASS_EN
    // Register file writes before it reads, so the last outstanding write lands in time.
    if (wb_en && wb_dest == id_src1 && cnt[id_src1] == CNT_W'(1))
      hazard1 = 1'b0;
    if (wb_en && wb_dest == id_src2 && cnt[id_src2] == CNT_W'(1))
      hazard2 = 1'b0;
`endif
    full  = id_wb_en && (id_dest != '0) && (cnt[id_dest] == CNT_MAX);
    flush = ex_br_taken || (state == FLUSH);
    stall = id_valid && !flush && (hazard1 || hazard2 || full);
    issue = id_valid && !flush && !stall;
    wb_spur = wb_en && (wb_dest != '0) && (cnt[wb_dest] == '0);
  end

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    busy    = 1'b0;
    for (int r = 1; r < NUM_REGS; r++) begin
      inc_vec[r] = issue && id_wb_en && (id_dest == ADDR_W'(r));
      dec_vec[r] = wb_en && (wb_dest == ADDR_W'(r)) && (cnt[r] != '0);
      busy       = busy || (cnt[r] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++)
        cnt[r] <= '0;
      sb_err <= 1'b0;
    end else begin
      cnt[0] <= '0;
      for (int r = 1; r < NUM_REGS; r++)
        cnt[r] <= cnt_next(cnt[r], inc_vec[r], dec_vec[r]);
      if (wb_spur)
        sb_err <= 1'b1;
    end
  end

  // Branch flush sequencer; a taken branch seen while flushing is a wrong-path bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      flush_left <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ex_br_taken && FLUSH_CYCLES > 1) begin
            state      <= FLUSH;
            flush_left <= FL_LOAD;
          end
        end
        FLUSH: begin
          flush_left <= flush_left - 1'b1;
          if (flush_left <= FL_W'(1))
            state <= IDLE;
        end
        default: begin
          state      <= IDLE;
          flush_left <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scoreboard_ctrl.sv
// Directed bench for scoreboard_ctrl: reset, RAW stall, saturation, r0, flush and spurious write-back.
module tb_scoreboard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_src1;
  logic [4:0] id_src2;
  logic       id_use_src2;
  logic [4:0] id_dest;
  logic       id_wb_en;
  logic       ex_br_taken;
  logic       wb_en;
  logic [4:0] wb_dest;
  logic       stall;
  logic       issue;
  logic       flush;
  logic       busy;
  logic       sb_err;

  int n_cmp = 0;
  int n_err = 0;

  scoreboard_ctrl #(.NUM_REGS(32), .ADDR_W(5), .CNT_W(2), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_use_src2(id_use_src2), .id_dest(id_dest), .id_wb_en(id_wb_en),
    .ex_br_taken(ex_br_taken), .wb_en(wb_en), .wb_dest(wb_dest),
    .stall(stall), .issue(issue), .flush(flush), .busy(busy), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_src1 = 0; id_src2 = 0; id_use_src2 = 0;
    id_dest = 0; id_wb_en = 0; ex_br_taken = 0; wb_en = 0; wb_dest = 0;
  endtask

  // Advance past the next rising edge; inputs driven afterwards settle before checks.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    cyc();
    rst = 0;

    // Post-reset state
    id_valid = 1; id_src1 = 5'd3; settle();
    chk("rst_stall", stall, 0);
    chk("rst_issue", issue, 1);
    chk("rst_flush", flush, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sberr", sb_err, 0);

    // Reset with a pending write to r3
    idle_inputs(); id_valid = 1; id_wb_en = 1; id_dest = 5'd3; settle();
    chk("p3_issue", issue, 1);
    cyc(); idle_inputs(); settle();
    chk("p3_busy", busy, 1);
    rst = 1; cyc(); rst = 0;
    id_valid = 1; id_src1 = 5'd3; settle();
    chk("p3_rst_busy", busy, 0);
    chk("p3_rst_stall", stall, 0);
    chk("p3_rst_issue", issue, 1);

    // RAW on r5
    idle_inputs(); id_valid = 1; id_wb_en = 1; id_dest = 5'd5; settle();
    chk("raw_prod_issue", issue, 1);
    cyc(); idle_inputs(); id_valid = 1; id_src1 = 5'd5; settle();
    chk("raw_stall_c1", stall, 1);
    chk("raw_issue_c1", issue, 0);
    cyc(); settle();
    chk("raw_stall_c2", stall, 1);
    cyc(); wb_en = 1; wb_dest = 5'd5; settle();
`ifdef SB_WB_BYPASS_EN
    chk("raw_wb_stall", stall, 0);
`else
    chk("raw_wb_stall", stall, 1);
`endif
    cyc(); wb_en = 0; settle();
    chk("raw_after_stall", stall, 0);
    chk("raw_after_issue", issue, 1);
    chk("raw_after_busy", busy, 0);

    // Saturation on r7
    idle_inputs(); id_valid = 1; id_wb_en = 1; id_dest = 5'd7;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk($sformatf("sat_issue%0d", i), issue, 1);
      cyc();
    end
    settle();
    chk("sat_full_stall", stall, 1);
    chk("sat_full_issue", issue, 0);
    cyc(); wb_en = 1; wb_dest = 5'd7; settle();
    chk("sat_wb_stall", stall, 1);
    cyc(); wb_en = 0; settle();
    chk("sat_4th_issue", issue, 1);
    cyc(); settle();
    chk("sat_back_full", stall, 1);
    idle_inputs(); wb_en = 1; wb_dest = 5'd7;
    cyc(); cyc(); cyc(); idle_inputs(); settle();
    chk("sat_drain_busy", busy, 0);
    chk("sat_drain_sberr", sb_err, 0);

    // src2 gating by id_use_src2
    id_valid = 1; id_wb_en = 1; id_dest = 5'd4; settle();
    chk("s2_prod_issue", issue, 1);
    cyc(); idle_inputs(); id_valid = 1; id_src2 = 5'd4; settle();
    chk("s2_unused_stall", stall, 0);
    id_use_src2 = 1; settle();
    chk("s2_used_stall", stall, 1);
    idle_inputs(); wb_en = 1; wb_dest = 5'd4;
    cyc(); idle_inputs(); settle();
    chk("s2_drain_busy", busy, 0);

    // r0 handling
    id_valid = 1; id_wb_en = 1; id_dest = 5'd0; settle();
    chk("r0_dest_issue", issue, 1);
    cyc(); idle_inputs(); settle();
    chk("r0_dest_busy", busy, 0);
    id_valid = 1; id_use_src2 = 1; settle();
    chk("r0_src_stall", stall, 0);
    idle_inputs(); wb_en = 1; wb_dest = 5'd0;
    cyc(); idle_inputs(); settle();
    chk("r0_wb_sberr", sb_err, 0);

    // Branch flush, second taken during flush ignored
    id_valid = 1; id_wb_en = 1; id_dest = 5'd8; ex_br_taken = 1; settle();
    chk("br_flush_c0", flush, 1);
    chk("br_issue_c0", issue, 0);
    chk("br_stall_c0", stall, 0);
    cyc(); settle();
    chk("br_flush_c1", flush, 1);
    chk("br_issue_c1", issue, 0);
    cyc(); ex_br_taken = 0; id_valid = 0; settle();
    chk("br_flush_c2", flush, 0);
    chk("br_busy", busy, 0);

    // Reset mid-flush
    ex_br_taken = 1; cyc(); ex_br_taken = 0;
    rst = 1; cyc(); rst = 0; settle();
    chk("br_rst_flush", flush, 0);

    // Spurious write-back to r9
    wb_en = 1; wb_dest = 5'd9; settle();
    chk("spur_pre_sberr", sb_err, 0);
    cyc(); wb_en = 0; settle();
    chk("spur_sberr", sb_err, 1);
    chk("spur_busy", busy, 0);
    cyc(); cyc(); settle();
    chk("spur_sberr_held", sb_err, 1);
    id_valid = 1; id_src1 = 5'd9; settle();
    chk("spur_r9_nostall", stall, 0);
    rst = 1; cyc(); rst = 0; settle();
    chk("spur_rst_sberr", sb_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
